// File: rtl/arith_seq_pkg.sv
// Shared definitions for the arithmetic sequencer: opcode encoding,
// FSM state encoding and a small opcode-class helper.
package arith_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // ADD and SUB finish in a single EXEC step and report a carry
    function automatic logic is_addsub(input logic [1:0] op);
        return (op == 2'(OP_ADD)) || (op == 2'(OP_SUB));
    endfunction

endpackage

// File: rtl/arith_seq_adder.sv
// WIDTH-bit ripple-carry adder shared by every datapath operation
// of the arithmetic sequencer.
module arith_seq_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry_s;

    // Ripple the carry from bit 0 upward
    always_comb begin
        carry_s    = '0;
        sum        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry_s[WIDTH];

endmodule

// File: rtl/arith_sequencer.sv
// Multi-cycle ADD/SUB/MUL/DIV sequencer with valid/ready handshakes on
// both sides. One shared ripple adder does all the arithmetic: MUL is
// LSB-first shift-add, DIV is MSB-first restoring division.
// Build option: define ARITH_SEQ_DIV_EN to include the divider; without
// it opcode DIV completes immediately with result 0 and err 1.
module arith_sequencer
    import arith_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 cout,
    output logic                 err
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    // hi_r/lo_r: MUL partial product / multiplier, DIV remainder / quotient
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [2*WIDTH-1:0] result_r;
    logic               cout_r;
    logic               err_r;

    logic [WIDTH-1:0]   add_a_s;
    logic [WIDTH-1:0]   add_b_s;
    logic               add_cin_s;
    logic [WIDTH-1:0]   sum_s;
    logic               carry_s;
    logic [WIDTH-1:0]   hi_nxt_s;
    logic [WIDTH-1:0]   lo_nxt_s;
    logic [CW-1:0]      cnt_dec_s;

    arith_seq_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (sum_s),
        .cout (carry_s)
    );

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign result    = result_r;
    assign cout      = cout_r;
    assign err       = err_r;
    assign cnt_dec_s = cnt_r - CW'(1);

    // Steer the shared adder operands according to the latched opcode
    always_comb begin
        add_a_s   = '0;
        add_b_s   = '0;
        add_cin_s = 1'b0;
        case (op_r)
            OP_ADD: begin
                add_a_s   = a_r;
                add_b_s   = b_r;
                add_cin_s = 1'b0;
            end
            OP_SUB: begin
                add_a_s   = a_r;
                add_b_s   = ~b_r;
                add_cin_s = 1'b1;
            end
            OP_MUL: begin
                add_a_s   = hi_r;
                add_b_s   = lo_r[0] ? a_r : {WIDTH{1'b0}};
                add_cin_s = 1'b0;
            end
`ifdef ARITH_SEQ_DIV_EN
            OP_DIV: begin
                // Trial subtraction of the divisor from the shifted remainder
                add_a_s   = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
                add_b_s   = ~b_r;
                add_cin_s = 1'b1;
            end
`endif
            default: begin
                add_a_s   = '0;
                add_b_s   = '0;
                add_cin_s = 1'b0;
            end
        endcase
    end

    // Next partial-product / remainder-quotient values for one EXEC step
    always_comb begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        case (op_r)
            OP_MUL: begin
                // Shift {carry, sum, multiplier} right by one
                hi_nxt_s = {carry_s, sum_s[WIDTH-1:1]};
                lo_nxt_s = {sum_s[0], lo_r[WIDTH-1:1]};
            end
`ifdef ARITH_SEQ_DIV_EN
            OP_DIV: begin
                // Shifted-out remainder MSB or adder carry means the trial fits
                if (hi_r[WIDTH-1] | carry_s) begin
                    hi_nxt_s = sum_s;
                    lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
                end else begin
                    hi_nxt_s = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
                    lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
                end
            end
`endif
            default: begin
                hi_nxt_s = hi_r;
                lo_nxt_s = lo_r;
            end
        endcase
    end

    // Sequencer FSM, operand latches, iteration counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            op_r     <= 2'b00;
            a_r      <= '0;
            b_r      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r  <= a;
                        b_r  <= b;
                        op_r <= op;
                        hi_r <= '0;
                        case (op)
                            OP_ADD, OP_SUB: begin
                                cnt_r   <= CW'(1);
                                lo_r    <= '0;
                                state_r <= ST_EXEC;
                            end
                            OP_MUL: begin
                                cnt_r   <= CW'(WIDTH);
                                lo_r    <= b;
                                state_r <= ST_EXEC;
                            end
                            OP_DIV: begin
`ifdef ARITH_SEQ_DIV_EN
                                if (b == {WIDTH{1'b0}}) begin
                                    cnt_r    <= '0;
                                    lo_r     <= '0;
                                    result_r <= {(2*WIDTH){1'b1}};
                                    cout_r   <= 1'b0;
                                    err_r    <= 1'b1;
                                    state_r  <= ST_DONE;
                                end else begin
                                    cnt_r   <= CW'(WIDTH);
                                    lo_r    <= a;
                                    state_r <= ST_EXEC;
                                end
`else
                                cnt_r    <= '0;
                                lo_r     <= '0;
                                result_r <= '0;
                                cout_r   <= 1'b0;
                                err_r    <= 1'b1;
                                state_r  <= ST_DONE;
`endif
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    cnt_r <= cnt_dec_s;
                    hi_r  <= hi_nxt_s;
                    lo_r  <= lo_nxt_s;
                    if (cnt_dec_s == {CW{1'b0}}) begin
                        state_r <= ST_DONE;
                        err_r   <= 1'b0;
                        if (is_addsub(op_r)) begin
                            result_r <= {{WIDTH{1'b0}}, sum_s};
                            cout_r   <= carry_s;
                        end else begin
                            result_r <= {hi_nxt_s, lo_nxt_s};
                            cout_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r  <= ST_IDLE;
                        result_r <= '0;
                        cout_r   <= 1'b0;
                        err_r    <= 1'b0;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= '0;
                    result_r <= '0;
                    cout_r   <= 1'b0;
                    err_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_sequencer.sv
// Directed, table-driven bench for arith_sequencer (WIDTH=4), plus
// hand-written back-pressure and mid-operation reset sequences.
// Expected DIV behaviour follows ARITH_SEQ_DIV_EN.
module tb_arith_sequencer;
    import arith_seq_pkg::*;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               cout;
    logic               err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_result;
        logic       exp_cout;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[$];

    arith_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, wait for the result, check it, then hand it off.
    task automatic run_op(input string tag, input logic [1:0] t_op, input logic [3:0] t_a,
                          input logic [3:0] t_b, input logic [7:0] e_res, input logic e_cout,
                          input logic e_err, input int e_lat, input bit hold);
        int lat;
        logic [7:0] held;
        @(negedge clk);
        op       = t_op;
        a        = t_a;
        b        = t_b;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = ~t_op;
        a        = ~t_a;
        b        = ~t_b;
        lat      = 1;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            if (lat >= 20) break;
            @(posedge clk);
            lat++;
        end
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
        chk({tag, "_result"}, 32'(result), 32'(e_res));
        chk({tag, "_cout"}, 32'(cout), 32'(e_cout));
        chk({tag, "_err"}, 32'(err), 32'(e_err));
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        if (hold) begin
            held = e_res;
            // Offer a new request while stalled; it must not be taken
            op       = OP_ADD;
            a        = 4'd1;
            b        = 4'd1;
            in_valid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk({tag, "_hold_result"}, 32'(result), 32'(held));
                chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
                chk({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drop_result"}, 32'(result), 32'd0);
        chk({tag, "_drop_err"}, 32'(err), 32'd0);
        chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;

        vecs.push_back('{OP_ADD, 4'd9,  4'd8,  8'h01, 1'b1, 1'b0, 2});
        vecs.push_back('{OP_ADD, 4'd3,  4'd4,  8'h07, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_ADD, 4'd15, 4'd15, 8'h0E, 1'b1, 1'b0, 2});
        vecs.push_back('{OP_SUB, 4'd3,  4'd5,  8'h0E, 1'b0, 1'b0, 2});
        vecs.push_back('{OP_SUB, 4'd5,  4'd3,  8'h02, 1'b1, 1'b0, 2});
        vecs.push_back('{OP_SUB, 4'd7,  4'd7,  8'h00, 1'b1, 1'b0, 2});
        vecs.push_back('{OP_MUL, 4'd15, 4'd15, 8'hE1, 1'b0, 1'b0, 5});
        vecs.push_back('{OP_MUL, 4'd0,  4'd7,  8'h00, 1'b0, 1'b0, 5});
        vecs.push_back('{OP_MUL, 4'd3,  4'd5,  8'h0F, 1'b0, 1'b0, 5});
        vecs.push_back('{OP_MUL, 4'd13, 4'd11, 8'h8F, 1'b0, 1'b0, 5});
`ifdef ARITH_SEQ_DIV_EN
        vecs.push_back('{OP_DIV, 4'd13, 4'd4,  8'h13, 1'b0, 1'b0, 5});
        vecs.push_back('{OP_DIV, 4'd6,  4'd0,  8'hFF, 1'b0, 1'b1, 1});
        vecs.push_back('{OP_DIV, 4'd15, 4'd1,  8'h0F, 1'b0, 1'b0, 5});
        vecs.push_back('{OP_DIV, 4'd7,  4'd9,  8'h70, 1'b0, 1'b0, 5});
`else
        vecs.push_back('{OP_DIV, 4'd13, 4'd4,  8'h00, 1'b0, 1'b1, 1});
        vecs.push_back('{OP_DIV, 4'd6,  4'd0,  8'h00, 1'b0, 1'b1, 1});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        a         = 4'd0;
        b         = 4'd0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // out_ready pulsed while idle must not disturb anything
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_out_ready_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_ready_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_result, vecs[i].exp_cout, vecs[i].exp_err,
                   vecs[i].exp_lat, 1'b0);
        end

        // Back-pressure: result held for 10 stalled cycles
        run_op("bp_mul", OP_MUL, 4'd3, 4'd5, 8'h0F, 1'b0, 1'b0, 5, 1'b1);

        // Reset during the second EXEC cycle of a MUL discards it
        @(negedge clk);
        op       = OP_MUL;
        a        = 4'd15;
        b        = 4'd15;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_result", 32'(result), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("rst_mid_no_result", 32'(seen), 32'd0);
        run_op("post_rst_add", OP_ADD, 4'd9, 4'd8, 8'h01, 1'b1, 1'b0, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
